// File: rtl/entropy_encoder.sv
// Purpose: turns zigzag-ordered quantized coefficients (64 per block, DC first) into (run, size, value) symbols with DC prediction, zero runs, ZRL and EOB.
// Latency: a symbol is presented the cycle after its coefficient is accepted; one coefficient per cycle while no ZRL expansion is pending.
// Backpressure: the output symbol register holds while valid_out && !ready_in; ready_out drops while that symbol is stalled or while ZRLs are being expanded.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   coeff_in/valid_in       signed 12-bit coefficient in, with ready_out as its handshake
//   value_out, run_out,     symbol fields: amplitude bits (right aligned), preceding zero run,
//   size_out, dc_out,       amplitude length, DC marker and end-of-block marker
//   last_out
//   valid_out/ready_in      symbol handshake
//   sym_count_out           symbols in the most recent completed block (only with ENTROPY_ENC_SYMCOUNT_EN)
//
// Parameter DELTA_ENCODE: 1 codes DC as a difference from the previous reconstructed DC, 0 codes it directly.
// Optional macro ENTROPY_ENC_SYMCOUNT_EN adds the per-block symbol counter and its port.
module entropy_encoder #(
    parameter bit DELTA_ENCODE = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [11:0] coeff_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [10:0] value_out,
    output logic [4:0]  run_out,
    output logic [4:0]  size_out,
    output logic        dc_out,
    output logic        last_out,
    output logic        valid_out,
    input  logic        ready_in
`ifdef ENTROPY_ENC_SYMCOUNT_EN
    ,
    output logic [6:0]  sym_count_out
`endif
);

    typedef enum logic {ST_ACCEPT, ST_ZRL} state_t;

    state_t             state;
    logic [5:0]         k;
    logic [5:0]         r;
    logic signed [11:0] pred;
    logic [1:0]         zrl_left;

    // Coefficient symbol parked while its leading ZRLs drain out.
    logic [10:0]        hold_value;
    logic [3:0]         hold_run;
    logic [4:0]         hold_size;
    logic               hold_last;

    logic               accept;
    logic               consume;

    assign consume   = valid_out & ready_in;
    assign ready_out = ~rst_in & (state == ST_ACCEPT) & (~valid_out | ready_in);
    assign accept    = valid_in & ready_out;

    logic signed [11:0] coeff_s;
    logic signed [11:0] coeff_cl;
    logic signed [12:0] diff;
    logic signed [11:0] d_sat;
    logic [11:0]        pred_next;
    logic signed [11:0] amp_in;
    logic [10:0]        neg;
    logic [10:0]        mag;
    logic [10:0]        vm1;
    logic [10:0]        mask;
    logic [4:0]         amp_size;
    logic [10:0]        amp_value;
    logic               coeff_zero;

    always_comb begin
        coeff_s  = $signed(coeff_in);
        // -2048 has no 11-bit magnitude; fold it onto -2047.
        coeff_cl = (coeff_in == 12'h800) ? 12'sh801 : coeff_s;

        // DC difference at 13 bits, then saturated to +/-2047.
        diff = {coeff_s[11], coeff_s} - {pred[11], pred};
        if (diff > 13'sd2047) begin
            d_sat = 12'sd2047;
        end else if (diff < -13'sd2047) begin
            d_sat = -12'sd2047;
        end else begin
            d_sat = diff[11:0];
        end
        // Predictor follows the decoder's reconstruction, not the raw input.
        pred_next = pred + d_sat;

        if (k == 6'd0) begin
            amp_in = DELTA_ENCODE ? d_sat : coeff_cl;
        end else begin
            amp_in = coeff_cl;
        end

        // |v| < 2048, so 11-bit arithmetic is exact for the magnitude and for the low bits of v-1.
        neg = 11'd0 - amp_in[10:0];
        mag = amp_in[11] ? neg : amp_in[10:0];

        amp_size = 5'd0;
        for (int i = 0; i < 11; i++) begin
            if (mag[i]) begin
                amp_size = 5'(i + 1);
            end
        end

        vm1       = amp_in[10:0] - 11'd1;
        mask      = ~(11'h7FF << amp_size);
        amp_value = amp_in[11] ? (vm1 & mask) : amp_in[10:0];

        coeff_zero = (coeff_in == 12'd0);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= ST_ACCEPT;
            k          <= 6'd0;
            r          <= 6'd0;
            pred       <= 12'sd0;
            zrl_left   <= 2'd0;
            hold_value <= 11'd0;
            hold_run   <= 4'd0;
            hold_size  <= 5'd0;
            hold_last  <= 1'b0;
            valid_out  <= 1'b0;
            last_out   <= 1'b0;
            dc_out     <= 1'b0;
            value_out  <= 11'd0;
            run_out    <= 5'd0;
            size_out   <= 5'd0;
        end else begin
            case (state)
                ST_ACCEPT: begin
                    if (accept) begin
                        k <= k + 6'd1;
                        if (k == 6'd0) begin
                            // DC always produces a symbol, even for a zero difference.
                            valid_out <= 1'b1;
                            dc_out    <= 1'b1;
                            last_out  <= 1'b0;
                            run_out   <= 5'd0;
                            size_out  <= amp_size;
                            value_out <= amp_value;
                            r         <= 6'd0;
                            if (DELTA_ENCODE) begin
                                pred <= pred_next;
                            end
                        end else if (coeff_zero) begin
                            if (k == 6'd63) begin
                                // EOB replaces any trailing ZRLs.
                                valid_out <= 1'b1;
                                dc_out    <= 1'b0;
                                last_out  <= 1'b1;
                                run_out   <= 5'd0;
                                size_out  <= 5'd0;
                                value_out <= 11'd0;
                                r         <= 6'd0;
                            end else begin
                                r <= r + 6'd1;
                                if (consume) begin
                                    valid_out <= 1'b0;
                                end
                            end
                        end else begin
                            r         <= 6'd0;
                            valid_out <= 1'b1;
                            dc_out    <= 1'b0;
                            if (r[5:4] != 2'd0) begin
                                // First ZRL goes out now; the rest follow one per consume.
                                run_out    <= 5'd15;
                                size_out   <= 5'd0;
                                value_out  <= 11'd0;
                                last_out   <= 1'b0;
                                hold_run   <= r[3:0];
                                hold_size  <= amp_size;
                                hold_value <= amp_value;
                                hold_last  <= (k == 6'd63);
                                zrl_left   <= r[5:4] - 2'd1;
                                state      <= ST_ZRL;
                            end else begin
                                run_out   <= {1'b0, r[3:0]};
                                size_out  <= amp_size;
                                value_out <= amp_value;
                                last_out  <= (k == 6'd63);
                            end
                        end
                    end else if (consume) begin
                        valid_out <= 1'b0;
                    end
                end
                ST_ZRL: begin
                    if (consume) begin
                        if (zrl_left != 2'd0) begin
                            // Output register already shows a ZRL; just keep it valid.
                            zrl_left <= zrl_left - 2'd1;
                        end else begin
                            run_out   <= {1'b0, hold_run};
                            size_out  <= hold_size;
                            value_out <= hold_value;
                            last_out  <= hold_last;
                            state     <= ST_ACCEPT;
                        end
                    end
                end
                default: state <= ST_ACCEPT;
            endcase
        end
    end

`ifdef ENTROPY_ENC_SYMCOUNT_EN
    logic [6:0] blk_cnt;

    // Counts consumed symbols; publishes the total when the block's last symbol leaves.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            blk_cnt       <= 7'd0;
            sym_count_out <= 7'd0;
        end else if (consume) begin
            if (last_out) begin
                sym_count_out <= blk_cnt + 7'd1;
                blk_cnt       <= 7'd0;
            end else begin
                blk_cnt <= blk_cnt + 7'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_entropy_encoder.sv
// Purpose: directed self-checking bench for entropy_encoder with hand-computed symbol lists.
// Latency: n/a (bench).
// Backpressure: ready_in driven directly by the stimulus sequence.
module tb_entropy_encoder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [11:0] coeff_in;
    logic        valid_in;
    logic        ready_out;
    logic [10:0] value_out;
    logic [4:0]  run_out;
    logic [4:0]  size_out;
    logic        dc_out;
    logic        last_out;
    logic        valid_out;
    logic        ready_in;
`ifdef ENTROPY_ENC_SYMCOUNT_EN
    logic [6:0]  sym_count_out;
`endif

    entropy_encoder dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .coeff_in  (coeff_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .value_out (value_out),
        .run_out   (run_out),
        .size_out  (size_out),
        .dc_out    (dc_out),
        .last_out  (last_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
`ifdef ENTROPY_ENC_SYMCOUNT_EN
        ,
        .sym_count_out (sym_count_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int lowcnt;
    int blk [64];

    logic [22:0] got_q [$];
    logic [22:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [22:0] sym(input bit dc, input bit last, input int run, input int size, input int value);
        logic [4:0]  r5;
        logic [4:0]  s5;
        logic [10:0] v11;
        r5  = run[4:0];
        s5  = size[4:0];
        v11 = value[10:0];
        return {dc, last, r5, s5, v11};
    endfunction

    // Record every symbol that will be consumed at the next rising edge.
    always @(negedge clk_in) begin
        if (valid_out === 1'b1 && ready_in === 1'b1 && rst_in === 1'b0) begin
            got_q.push_back({dc_out, last_out, run_out, size_out, value_out});
        end
    end

    task automatic do_reset();
        rst_in   = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        coeff_in = 12'd0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_coeff(input int c);
        bit acc;
        acc      = 1'b0;
        coeff_in = c[11:0];
        valid_in = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk_in);
            if (ready_out) acc = 1'b1;
            else lowcnt++;
            @(posedge clk_in);
            #1;
        end
        valid_in = 1'b0;
        if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = 0;
    endtask

    task automatic send_blk();
        for (int i = 0; i < 64; i++) send_coeff(blk[i]);
    endtask

    task automatic drain();
        repeat (8) @(posedge clk_in);
        #1;
    endtask

    task automatic cmp_syms(input string tag);
        int n;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_sym%0d", tag, i), {9'd0, got_q[i]}, {9'd0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_in   = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        coeff_in = 12'd0;

        // Reset state
        @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_ready", {31'd0, ready_out}, 32'd0);
        chk("rst_outs", {8'd0, valid_out, last_out, dc_out, value_out, run_out, size_out}, 32'd0);
        do_reset();
        @(negedge clk_in);
        chk("post_rst_ready", {31'd0, ready_out}, 32'd1);
        @(posedge clk_in);
        #1;

        // DC then zeros
        do_reset();
        lowcnt = 0;
        clear_blk();
        blk[0] = 5;
        send_blk();
        drain();
        exp_q.push_back(sym(1, 0, 0, 3, 5));
        exp_q.push_back(sym(0, 1, 0, 0, 0));
        cmp_syms("dc_zeros");
        chk("dc_zeros_ready_low", lowcnt, 0);
`ifdef ENTROPY_ENC_SYMCOUNT_EN
        chk("dc_zeros_symcnt", {25'd0, sym_count_out}, 32'd2);
`endif

        // Negatives and AC clamp
        do_reset();
        clear_blk();
        blk[0] = -3;
        blk[1] = -1;
        blk[2] = -2048;
        send_blk();
        drain();
        exp_q.push_back(sym(1, 0, 0, 2, 0));
        exp_q.push_back(sym(0, 0, 0, 1, 0));
        exp_q.push_back(sym(0, 0, 0, 11, 0));
        exp_q.push_back(sym(0, 1, 0, 0, 0));
        cmp_syms("neg");
`ifdef ENTROPY_ENC_SYMCOUNT_EN
        chk("neg_symcnt", {25'd0, sym_count_out}, 32'd4);
`endif

        // Long run with two ZRLs
        do_reset();
        lowcnt = 0;
        clear_blk();
        blk[40] = 7;
        send_blk();
        drain();
        exp_q.push_back(sym(1, 0, 0, 0, 0));
        exp_q.push_back(sym(0, 0, 15, 0, 0));
        exp_q.push_back(sym(0, 0, 15, 0, 0));
        exp_q.push_back(sym(0, 0, 7, 3, 7));
        exp_q.push_back(sym(0, 1, 0, 0, 0));
        cmp_syms("long_run");
        chk("long_run_ready_low", lowcnt, 2);

        // Nonzero final coefficient: three ZRLs, last symbol flagged, no EOB
        do_reset();
        clear_blk();
        blk[63] = 1;
        send_blk();
        drain();
        exp_q.push_back(sym(1, 0, 0, 0, 0));
        exp_q.push_back(sym(0, 0, 15, 0, 0));
        exp_q.push_back(sym(0, 0, 15, 0, 0));
        exp_q.push_back(sym(0, 0, 15, 0, 0));
        exp_q.push_back(sym(0, 1, 14, 1, 1));
        cmp_syms("final_nz");
`ifdef ENTROPY_ENC_SYMCOUNT_EN
        chk("final_nz_symcnt", {25'd0, sym_count_out}, 32'd5);
`endif

        // DC saturation across three blocks
        do_reset();
        clear_blk();
        blk[0] = 2047;
        send_blk();
        blk[0] = -2048;
        send_blk();
        blk[0] = 0;
        send_blk();
        drain();
        exp_q.push_back(sym(1, 0, 0, 11, 2047));
        exp_q.push_back(sym(0, 1, 0, 0, 0));
        exp_q.push_back(sym(1, 0, 0, 11, 0));
        exp_q.push_back(sym(0, 1, 0, 0, 0));
        exp_q.push_back(sym(1, 0, 0, 0, 0));
        exp_q.push_back(sym(0, 1, 0, 0, 0));
        cmp_syms("dc_sat");

        // Backpressure mid-block, then reset at k = 20
        do_reset();
        send_coeff(1);
        send_coeff(2);
        ready_in = 1'b0;
        coeff_in = 12'd4;
        valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            chk($sformatf("bp_hold%0d", i),
                {7'd0, ready_out, valid_out, dc_out, last_out, run_out, size_out, value_out},
                {7'd0, 1'b0, 1'b1, sym(0, 0, 0, 2, 2)});
            @(posedge clk_in);
            #1;
        end
        ready_in = 1'b1;
        send_coeff(4);
        for (int i = 3; i < 10; i++) send_coeff(0);
        send_coeff(1);
        for (int i = 11; i < 19; i++) send_coeff(0);
        send_coeff(6);
        ready_in = 1'b0;
        rst_in   = 1'b1;
        coeff_in = 12'd5;
        valid_in = 1'b1;
        @(negedge clk_in);
        chk("rst_mid_ready", {31'd0, ready_out}, 32'd0);
        chk("rst_mid_pending", {31'd0, valid_out}, 32'd1);
        @(posedge clk_in);
        #1;
        chk("rst_mid_valid", {31'd0, valid_out}, 32'd0);
        rst_in   = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        exp_q.push_back(sym(1, 0, 0, 1, 1));
        exp_q.push_back(sym(0, 0, 0, 2, 2));
        exp_q.push_back(sym(0, 0, 0, 3, 4));
        exp_q.push_back(sym(0, 0, 7, 1, 1));
        cmp_syms("bp");
        clear_blk();
        blk[0] = 9;
        send_blk();
        drain();
        exp_q.push_back(sym(1, 0, 0, 4, 9));
        exp_q.push_back(sym(0, 1, 0, 0, 0));
        cmp_syms("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/entropy_encoder.md
# entropy_encoder

Encoder-side counterpart of the entropy decoder. It consumes quantized coefficients in zigzag order, 64 per block, coefficient 0 being DC. It emits JPEG-style (run, size, value) symbols: DC differential coding, zero-run counting, ZRL and EOB insertion. It sits between the quantizer/zigzag stage and the bitstream packer, with valid/ready on both sides.

## Interface
- DELTA_ENCODE, 1, 1: DC is coded as the difference from the previous block's reconstructed DC; 0: DC is coded directly.

- clk_in  input  1  clock
- rst_in  input  1  synchronous, active-high reset
- coeff_in  input  12  signed quantized coefficient, zigzag order
- valid_in  input  1  coeff_in valid
- ready_out  output  1  encoder accepts coeff_in this cycle
- value_out  output  11  amplitude bits, right-aligned, upper bits 0
- run_out  output  5  zeros preceding this coefficient (0..15)
- size_out  output  5  amplitude bit length (0..11)
- dc_out  output  1  symbol is the DC symbol of a block
- last_out  output  1  final symbol of the block
- valid_out  output  1  symbol valid
- ready_in  input  1  downstream accepts symbol

## Operation
- An input is accepted when valid_in && ready_out. A symbol is consumed when valid_out && ready_in.
- Index counter k (6 bit) counts 0..63 and wraps to 0 after 63. Run counter r (6 bit) counts zeros since the last nonzero AC.
- Amplitude coding of value v:
  - size = bit length of |v|.
  - value_out = v when v > 0, else low `size` bits of (v-1).
  - v = 0 gives size 0, value 0.
- AC clamp: coeff_in = -2048 is treated as -2047.
- DC (k = 0) always emits one symbol with dc_out = 1 and run 0, even when the difference is 0.
  - With DELTA_ENCODE = 1: d = coeff_in - pred, computed at 13 bits and saturated to ±2047. pred <= pred + d_sat, so pred tracks the decoder's reconstruction. r <= 0.
  - With DELTA_ENCODE = 0: code the clamped coeff_in directly.
- AC zero, k < 63: r <= r + 1; no symbol.
- AC zero, k = 63: emit EOB (run 0, size 0, value 0, last_out = 1). Any pending ZRLs are discarded.
- AC nonzero:
  - Emit floor(r/16) ZRL symbols (run 15, size 0, value 0), then (r mod 16, size, value).
  - The last of these carries last_out = 1 if k = 63; no EOB follows in that case.
  - Then r <= 0.
- State machine:
  - ACCEPT: normal operation.
  - ZRL: entered from ACCEPT on a nonzero AC with r ≥ 16. The coefficient is held in a register and one ZRL is emitted per consumed symbol. The held symbol is emitted when the remaining ZRL count reaches 0, then the machine returns to ACCEPT.
- The symbol register holds all output fields stable while valid_out && !ready_in.

## Timing
- Latency: a symbol appears on the cycle after its coefficient is accepted.
- Throughput: one coefficient per cycle in ACCEPT with no backpressure.
- ready_out = (state == ACCEPT) && (!valid_out || ready_in), and is forced 0 while rst_in is high.
- In ZRL state, ready_out = 0 for floor(r/16) symbol-consume opportunities.
- Reset values:
  - valid_out 0, last_out 0, dc_out 0, value/run/size 0.
  - k 0, r 0, pred 0, state ACCEPT.
- Reset mid-block discards the partial block. The next accepted coefficient is DC with pred = 0.
- Simultaneous accept and consume in the same cycle is legal; the symbol register reloads.

## Configuration
- ENTROPY_ENC_SYMCOUNT_EN defined:
  - Adds output sym_count_out[6:0], the number of symbols emitted for the most recent completed block.
  - It updates on the cycle its last_out symbol is consumed and resets to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- DC then zeros: block DC 5, then 63 zeros, pred 0. Required symbols:
  - (dc, run 0, size 3, value 5)
  - EOB (run 0, size 0, last = 1)
  - Sym count 2.
- Negatives: DC -3 (pred 0) gives size 2, value 2'b00. AC k=1 of -1 gives run 0, size 1, value 0. AC -2048 gives size 11, value 0 (clamped to -2047).
- Long run: DC 0, zeros k = 1..39, k = 40 = 7, rest zero. Required symbols:
  - DC symbol
  - Two ZRLs (15, 0)
  - (run 7, size 3, value 7)
  - EOB
  - ready_out low for 2 cycles.
- Final nonzero: k = 63 = 1, all other AC zero. Required symbols, with no EOB after:
  - Three ZRLs
  - (run 14, size 1, value 1, last = 1)
- DC saturation: block 1 DC 2047, block 2 DC -2048, DELTA_ENCODE = 1.
  - Block 2 DC diff saturates to -2047, giving size 11, value 0.
  - Block 3 DC 0 then codes diff 0 (pred 0).
- Backpressure/reset: with ready_in held low 5 cycles mid-block, outputs stay stable and ready_out = 0. Asserting rst_in at k = 20 gives:
  - valid_out 0 next cycle.
  - The following input coded as DC with pred 0.
